// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: moves 16-bit data between general registers over the
// shared register bus. Commands (MOV, LDI, optional SWAP) arrive on a
// valid/ready handshake; the sequencer drives one-hot read enables (ea_o) and
// active-low write strobes (r_w_o), holding bus data in tmp between phases.
//
// Optional feature macro: RBS_SWAP_EN -- builds the SWAP op (RD_B/WR_A states
// and the second holding register). Without it, op 2'b10 is rejected as illegal.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready_o high
// RD_A   | ea[src] high, tmp captures bus_in at the closing edge
// RD_B   | ea[dst] high, tmp2 captures bus_in (SWAP only)
// WR_A   | bus_out = tmp2, r_w[src] low (SWAP only)
// WR_B   | bus_out = tmp, r_w[dst] low, done pulse
// ERR    | rejected command, err pulse, no bus activity

module reg_bus_sequencer #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic            clk_i,
    input  logic            clr_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_op_i,
    input  logic [AW-1:0]   cmd_src_i,
    input  logic [AW-1:0]   cmd_dst_i,
    input  logic [15:0]     cmd_imm_i,
    input  logic [15:0]     bus_in_i,
    output logic [NREG-1:0] ea_o,
    output logic [NREG-1:0] r_w_o,
    output logic [15:0]     bus_out_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_WR_B = 3'd2,
`ifdef RBS_SWAP_EN
        S_RD_B = 3'd4,
        S_WR_A = 3'd5,
`endif
        S_ERR  = 3'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [15:0]   tmp_q, tmp_d;
    logic          src_ok, dst_ok;
`ifdef RBS_SWAP_EN
    logic          swap_q, swap_d;
    logic [15:0]   tmp2_q, tmp2_d;
`endif

    // State, latched indices and holding registers; reset drops any command in flight.
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            tmp_q   <= '0;
`ifdef RBS_SWAP_EN
            swap_q  <= 1'b0;
            tmp2_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            tmp_q   <= tmp_d;
`ifdef RBS_SWAP_EN
            swap_q  <= swap_d;
            tmp2_q  <= tmp2_d;
`endif
        end
    end

    // Next-state: command decode and validation in IDLE, then fixed phase walk.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        tmp_d   = tmp_q;
`ifdef RBS_SWAP_EN
        swap_d  = swap_q;
        tmp2_d  = tmp2_q;
`endif
        src_ok  = int'(cmd_src_i) < NREG;
        dst_ok  = int'(cmd_dst_i) < NREG;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    src_d = cmd_src_i;
                    dst_d = cmd_dst_i;
`ifdef RBS_SWAP_EN
                    swap_d = (cmd_op_i == 2'b10);
`endif
                    case (cmd_op_i)
                        2'b00: state_d = (src_ok && dst_ok) ? S_RD_A : S_ERR;
                        2'b01: begin
                            if (dst_ok) begin
                                state_d = S_WR_B;
                                tmp_d   = cmd_imm_i;
                            end else begin
                                state_d = S_ERR;
                            end
                        end
`ifdef RBS_SWAP_EN
                        2'b10: state_d = (src_ok && dst_ok) ? S_RD_A : S_ERR;
`endif
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_RD_A: begin
                tmp_d = bus_in_i;
`ifdef RBS_SWAP_EN
                state_d = swap_q ? S_RD_B : S_WR_B;
`else
                state_d = S_WR_B;
`endif
            end
`ifdef RBS_SWAP_EN
            S_RD_B: begin
                tmp2_d  = bus_in_i;
                state_d = S_WR_A;
            end
            S_WR_A: state_d = S_WR_B;
`endif
            S_WR_B:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from registered state and indices.
    always_comb begin
        ea_o        = '0;
        r_w_o       = '1;
        bus_out_o   = '0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        busy_o      = (state_q != S_IDLE);
        cmd_ready_o = (state_q == S_IDLE);

        case (state_q)
            S_RD_A: begin
                for (int i = 0; i < NREG; i++) begin
                    if (src_q == AW'(i)) ea_o[i] = 1'b1;
                end
            end
`ifdef RBS_SWAP_EN
            S_RD_B: begin
                for (int i = 0; i < NREG; i++) begin
                    if (dst_q == AW'(i)) ea_o[i] = 1'b1;
                end
            end
            S_WR_A: begin
                bus_out_o = tmp2_q;
                for (int i = 0; i < NREG; i++) begin
                    if (src_q == AW'(i)) r_w_o[i] = 1'b0;
                end
            end
`endif
            S_WR_B: begin
                bus_out_o = tmp_q;
                done_o    = 1'b1;
                for (int i = 0; i < NREG; i++) begin
                    if (dst_q == AW'(i)) r_w_o[i] = 1'b0;
                end
            end
            S_ERR:   err_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: models the external register bank, keeps a
// scoreboard of expected bus writes and checks cycle-level handshake behaviour.
module tb_reg_bus_sequencer;

    localparam int NREG = 8;
    localparam int AW   = 4;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } wr_t;

    logic            clk = 1'b0;
    logic            clr;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [AW-1:0]   cmd_src;
    logic [AW-1:0]   cmd_dst;
    logic [15:0]     cmd_imm;
    logic [15:0]     bus_in;
    logic [NREG-1:0] ea;
    logic [NREG-1:0] r_w;
    logic [15:0]     bus_out;
    logic            busy;
    logic            done;
    logic            err;

    logic [15:0]     bank    [NREG];
    logic [15:0]     exp_reg [NREG];
    logic            bank_load;
    logic            mon_en;
    wr_t             sb_q [$];
    int              n_asrt = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    reg_bus_sequencer #(.NREG(NREG), .AW(AW)) dut (
        .clk_i       (clk),
        .clr_i       (clr),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_src_i   (cmd_src),
        .cmd_dst_i   (cmd_dst),
        .cmd_imm_i   (cmd_imm),
        .bus_in_i    (bus_in),
        .ea_o        (ea),
        .r_w_o       (r_w),
        .bus_out_o   (bus_out),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    function automatic logic [15:0] init_val(int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    function automatic logic [NREG-1:0] rw_low(int idx);
        logic [NREG-1:0] m;
        m = '1;
        m[idx] = 1'b0;
        return m;
    endfunction

    function automatic logic [NREG-1:0] ea_one(int idx);
        logic [NREG-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Register bank: Qa gated by Ea and OR-ed onto the bus.
    always_comb begin
        bus_in = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ea[i]) bus_in = bus_in | bank[i];
        end
    end

    // Register bank storage: writes D when its R_W is low at the edge.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_load) bank[i] <= init_val(i);
            else if (r_w[i] === 1'b0) bank[i] <= bus_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every observed write must match the oldest scoreboard entry.
    always @(negedge clk) begin
        int w;
        wr_t e;
        if (mon_en) begin
            if (r_w !== {NREG{1'b1}}) begin
                w = -1;
                for (int i = NREG - 1; i >= 0; i--) begin
                    if (r_w[i] === 1'b0) w = i;
                end
                chk("rw_onehot", $countones(~r_w), 1);
                n_asrt++;
                assert (sb_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_write: observed write R%0d=%0h expected none", w, bus_out);
                end
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_wr_idx", w, e.idx);
                    chk("sb_wr_val", bus_out, e.val);
                end
            end
            if (ea !== '0) chk("ea_onehot", $countones(ea), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input int src, input int dst, input logic [15:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = AW'(src);
        cmd_dst   = AW'(dst);
        cmd_imm   = imm;
    endtask

    task automatic exp_write(input int idx, input logic [15:0] v);
        wr_t e;
        e.idx = idx;
        e.val = v;
        sb_q.push_back(e);
        exp_reg[idx] = v;
    endtask

    task automatic check_bank();
        for (int i = 0; i < NREG; i++) chk($sformatf("bank_R%0d", i), bank[i], exp_reg[i]);
    endtask

    task automatic ldi(input int dst, input logic [15:0] imm);
        chk("ldi_ready", cmd_ready, 1'b1);
        drive(2'b01, 0, dst, imm);
        exp_write(dst, imm);
        tick();
        cmd_valid = 1'b0;
        chk("ldi_done", done, 1'b1);
        tick();
    endtask

    task automatic err_case(input string tag, input logic [1:0] op, input int src, input int dst);
        drive(op, src, dst, 16'hDEAD);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_err"}, err, 1'b1);
        chk({tag, "_ea"}, ea, '0);
        chk({tag, "_rw"}, r_w, {NREG{1'b1}});
        chk({tag, "_ready"}, cmd_ready, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        tick();
        chk({tag, "_err_clr"}, err, 1'b0);
        chk({tag, "_ready_back"}, cmd_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int d;

        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_imm   = '0;
        bank_load = 1'b1;
        mon_en    = 1'b0;
        for (int i = 0; i < NREG; i++) exp_reg[i] = init_val(i);

        // Reset values
        tick();
        tick();
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ea", ea, '0);
        chk("rst_rw", r_w, {NREG{1'b1}});
        chk("rst_bus_out", bus_out, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        bank_load = 1'b0;
        clr       = 1'b1;
        mon_en    = 1'b1;
        tick();

        // LDI R3 = 0xA5C3
        drive(2'b01, 0, 3, 16'hA5C3);
        exp_write(3, 16'hA5C3);
        tick();
        cmd_valid = 1'b0;
        chk("ldi_rw", r_w, rw_low(3));
        chk("ldi_bus_out", bus_out, 16'hA5C3);
        chk("ldi_done", done, 1'b1);
        chk("ldi_busy", busy, 1'b1);
        chk("ldi_ready_low", cmd_ready, 1'b0);
        tick();
        chk("ldi_rw_release", r_w, {NREG{1'b1}});
        chk("ldi_done_clr", done, 1'b0);
        chk("ldi_ready_back", cmd_ready, 1'b1);
        chk("ldi_R3", bank[3], 16'hA5C3);

        // LDI R1 = 0x1234, then MOV R1 -> R6
        ldi(1, 16'h1234);
        drive(2'b00, 1, 6, 16'h0000);
        exp_write(6, exp_reg[1]);
        tick();
        cmd_valid = 1'b0;
        chk("mov_ea", ea, ea_one(1));
        chk("mov_rd_rw", r_w, {NREG{1'b1}});
        chk("mov_rd_bus_out", bus_out, 16'h0000);
        chk("mov_rd_done", done, 1'b0);
        tick();
        chk("mov_wr_ea", ea, '0);
        chk("mov_wr_rw", r_w, rw_low(6));
        chk("mov_wr_bus_out", bus_out, 16'h1234);
        chk("mov_wr_done", done, 1'b1);
        tick();
        chk("mov_R6", bank[6], 16'h1234);
        chk("mov_R1", bank[1], 16'h1234);
        chk("mov_ready_back", cmd_ready, 1'b1);

        // MOV with src == dst leaves the value unchanged
        drive(2'b00, 3, 3, 16'h0000);
        exp_write(3, exp_reg[3]);
        tick();
        cmd_valid = 1'b0;
        chk("movself_ea", ea, ea_one(3));
        tick();
        chk("movself_rw", r_w, rw_low(3));
        chk("movself_bus_out", bus_out, 16'hA5C3);
        tick();
        check_bank();

`ifdef RBS_SWAP_EN
        // SWAP R2 <-> R5
        ldi(2, 16'h00FF);
        ldi(5, 16'hFF00);
        a = exp_reg[2];
        b = exp_reg[5];
        drive(2'b10, 2, 5, 16'h0000);
        exp_write(2, b);
        exp_write(5, a);
        tick();
        cmd_valid = 1'b0;
        chk("swap_c1_ea", ea, ea_one(2));
        chk("swap_c1_done", done, 1'b0);
        tick();
        chk("swap_c2_ea", ea, ea_one(5));
        chk("swap_c2_done", done, 1'b0);
        tick();
        chk("swap_c3_rw", r_w, rw_low(2));
        chk("swap_c3_bus_out", bus_out, 16'hFF00);
        chk("swap_c3_done", done, 1'b0);
        tick();
        chk("swap_c4_rw", r_w, rw_low(5));
        chk("swap_c4_bus_out", bus_out, 16'h00FF);
        chk("swap_c4_done", done, 1'b1);
        tick();
        chk("swap_ready_back", cmd_ready, 1'b1);
        chk("swap_R2", bank[2], 16'hFF00);
        chk("swap_R5", bank[5], 16'h00FF);
        err_case("swap_bad_dst", 2'b10, 2, 9);
`else
        a = 16'h0000;
        b = 16'h0000;
        err_case("swap_disabled", 2'b10, 2, 5);
`endif

        // Rejected commands
        err_case("op11", 2'b11, 1, 2);
        err_case("ldi_dst9", 2'b01, 0, 9);
        err_case("mov_src8", 2'b00, 8, 1);
        check_bank();

        // Reset during RD_A of a MOV
        drive(2'b00, 3, 0, 16'h0000);
        tick();
        cmd_valid = 1'b0;
        chk("rstmid_ea", ea, ea_one(3));
        clr = 1'b0;
        tick();
        chk("rstmid_ready", cmd_ready, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_rw", r_w, {NREG{1'b1}});
        chk("rstmid_ea_clr", ea, '0);
        chk("rstmid_done", done, 1'b0);
        clr = 1'b1;
        tick();
        chk("rstmid_done_after", done, 1'b0);
        chk("rstmid_err_after", err, 1'b0);
        chk("rstmid_R0", bank[0], exp_reg[0]);

        // Stream of LDIs with cmd_valid held high: one accept every two cycles
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        for (int i = 0; i < 4; i++) begin
            d = 4 + i;
            chk("stream_ready_idle", cmd_ready, 1'b1);
            cmd_op  = 2'b01;
            cmd_dst = AW'(d);
            cmd_imm = 16'($urandom);
            exp_write(d, cmd_imm);
            tick();
            chk("stream_ready_busy", cmd_ready, 1'b0);
            chk("stream_busy", busy, 1'b1);
            chk("stream_done", done, 1'b1);
            chk("stream_rw", r_w, rw_low(d));
            cmd_op  = 2'b11;
            cmd_dst = AW'(9);
            tick();
            chk("stream_err_none", err, 1'b0);
        end
        cmd_valid = 1'b0;
        tick();
        check_bank();
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bus_sequencer.md
# reg_bus_sequencer

Sequencer that moves data between a bank of 16-bit general registers over the shared register bus. It accepts transfer commands (move, load-immediate, optional swap) via a valid/ready handshake and drives each register's read-enable (Ea) and active-low write strobe (R_W), capturing bus data in an internal holding register between read and write phases. It sits between the instruction decoder and the register bank; register Qa outputs are OR-ed externally into `bus_in`.

## Interface
- `NREG`, 8, number of registers sequenced (2..16)
- `AW`, 3, register index width; must satisfy 2^AW >= NREG

- `CLK` in 1: single clock, all state updates on rising edge
- `CLR` in 1: reset, synchronous, active-low
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: sequencer can accept; high only in IDLE
- `cmd_op` in 2: 00 MOV, 01 LDI, 10 SWAP, 11 illegal
- `cmd_src` in AW: source register index (MOV/SWAP)
- `cmd_dst` in AW: destination register index
- `cmd_imm` in 16: immediate value (LDI)
- `bus_in` in 16: OR of all register Qa outputs
- `ea` out NREG: one-hot read enable to register Ea pins
- `r_w` out NREG: per-register R_W; 1 = hold, 0 = write D this edge
- `bus_out` out 16: data to all register D pins
- `busy` out 1: high in any non-IDLE state
- `done` out 1: one-cycle pulse in the final write cycle of a command
- `err` out 1: one-cycle pulse on a rejected command

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, ERR.
- Accept when `cmd_valid && cmd_ready` at a rising edge; latch op, src, dst, imm.
- MOV: IDLE → RD_A (`ea[src]`=1, tmp ← `bus_in`) → WR_B (`bus_out`=tmp, `r_w[dst]`=0, done) → IDLE.
- LDI: IDLE → WR_B with tmp = `cmd_imm`, `r_w[dst]`=0, done → IDLE.
- SWAP: RD_A (tmp ← R[src]) → RD_B (tmp2 ← R[dst]) → WR_A (`bus_out`=tmp2, `r_w[src]`=0) → WR_B (`bus_out`=tmp, `r_w[dst]`=0, done) → IDLE.
- Illegal op, or index ≥ NREG: IDLE → ERR (err=1, no ea/r_w activity) → IDLE.
- Outputs are Moore, decoded from registered state/indices: `ea` is all-zero outside RD_A/RD_B, `r_w` is all-ones outside WR_A/WR_B, and `bus_out`=0 outside the write states.
- At most one `ea` bit and at most one `r_w` bit are active in any cycle.
- src == dst: MOV and SWAP still execute fully; the register value is unchanged.
- Reset values: state IDLE, `ea`=0, `r_w`=all ones, `bus_out`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1, tmp/tmp2=0.
- Reset mid-command: the next edge with `CLR`=0 returns to IDLE; no partial write occurs after that edge and the command is dropped, with no done or err pulse.

## Timing
- Accept at edge k. MOV: read during cycle k..k+1, write edge k+2, done high in cycle k+1..k+2. LDI: write edge k+1. SWAP: writes at edges k+3 (src) and k+4 (dst).
- Earliest next accept is the edge after done or err; there is no back-to-back overlap.
- `bus_in` is sampled at the edge closing RD_A/RD_B; the register bank must present Qa combinationally in the same cycle.
- `cmd_*` inputs are ignored while `cmd_ready`=0.

## Configuration
- `RBS_SWAP_EN` defined: SWAP op is supported with the RD_B/WR_A states.
- Undefined: op 10 is illegal (ERR path, err pulse), RD_B/WR_A and tmp2 are not built, and MOV/LDI behaviour and latency are unchanged.

## Test plan
- Reset, then LDI dst=3 imm=0xA5C3 → `r_w[3]`=0 for exactly one cycle with `bus_out`=0xA5C3, done pulse, R3=0xA5C3.
- LDI R1=0x1234, then MOV src=1 dst=6 → `ea[1]` for one cycle, then `r_w[6]`=0 with `bus_out`=0x1234; R6=0x1234 and R1 unchanged.
- (RBS_SWAP_EN) R2=0x00FF, R5=0xFF00, SWAP 2,5 → R2=0xFF00, R5=0x00FF after 4 cycles; done in the 4th cycle only.
- op=11, or dst=9 with NREG=8 → err pulse, no `ea`/`r_w` activity, registers unchanged, `cmd_ready` back high the next cycle.
- Assert `CLR`=0 during RD_A of a MOV → next cycle IDLE, `r_w` all ones, destination unchanged, no done pulse.
- `cmd_valid` held high with a stream of LDIs → one command per 2 cycles; `cmd_ready` low while busy.
